// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory / memory-mapped IO port between two masters:
//   m0 - CPU load/store path
//   m1 - loader / DMA master
//
// Arbitration is per-cycle round-robin. A master may hold the port for a burst
// by raising its lock input. The burst is limited to MAX_LOCK consecutive
// grants, so the other master cannot be starved indefinitely. At most one
// request reaches the memory each cycle. Read data comes back one cycle later,
// steered to the master that issued the read.
//
// Ports
//   clk_i              clock, all state updates on the rising edge
//   rst_ni             asynchronous active-low reset
//   mN_req             request valid (N = 0, 1)
//   mN_we              1 = write, 0 = read
//   mN_lock            keep ownership of the port after this transfer
//   mN_addr            word address
//   mN_wdata           write data
//   mN_gnt             request accepted this cycle (combinational)
//   mN_rvalid          read data valid (registered, one cycle after the grant)
//   mN_rdata           read data, zero whenever mN_rvalid is low
//   mem_en             memory access this cycle
//   mem_we             memory write strobe
//   mem_addr           memory word address
//   mem_wdata          memory write data
//   mem_rdata          memory read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int DM_ADDRESS = 12,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_LOCK   = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,

   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic                  m0_lock,
   input  logic [DM_ADDRESS-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,

   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic                  m1_lock,
   input  logic [DM_ADDRESS-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,

   output logic                  mem_en,
   output logic                  mem_we,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   // The counter has to be able to hold the value MAX_LOCK itself.
   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Arbitration state
   logic             last_q;      // id of the most recently granted master
   logic             own_q;       // a locked owner currently holds the port
   logic             own_id_q;    // id of the locked owner
   logic [CNT_W-1:0] lock_cnt_q;  // consecutive grants given to the owner
   logic [1:0]       rpend_q;     // read issued last cycle, one bit per master

   // Decoded grant for this cycle
   logic             owner_req;
   logic             gnt_any;
   logic             gnt_id;
   logic             sel_we;
   logic             sel_lock;
   logic             owner_gnt;
   logic [CNT_W-1:0] cnt_inc;

   // Grant selection. An owner that is still requesting always wins. Otherwise
   // a lone requester wins, and a tie goes to whichever master was not granted
   // last. Nothing is granted while reset is asserted, so no access can reach
   // the memory during reset.
   always_comb begin
      owner_req = own_q & (own_id_q ? m1_req : m0_req);
      gnt_any   = 1'b0;
      gnt_id    = 1'b0;
      if (!rst_ni) begin
         gnt_any = 1'b0;
         gnt_id  = 1'b0;
      end else if (owner_req) begin
         gnt_any = 1'b1;
         gnt_id  = own_id_q;
      end else if (m0_req && m1_req) begin
         gnt_any = 1'b1;
         gnt_id  = ~last_q;
      end else if (m0_req) begin
         gnt_any = 1'b1;
         gnt_id  = 1'b0;
      end else if (m1_req) begin
         gnt_any = 1'b1;
         gnt_id  = 1'b1;
      end
   end

   assign m0_gnt = gnt_any & ~gnt_id;
   assign m1_gnt = gnt_any &  gnt_id;

   // Memory port mux. The idle port is driven to all zeros, so the IO decode
   // never sees a stale address or data word from an earlier access.
   always_comb begin
      sel_we    = gnt_id ? m1_we   : m0_we;
      sel_lock  = gnt_id ? m1_lock : m0_lock;
      mem_en    = gnt_any;
      mem_we    = gnt_any & sel_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_any) begin
         mem_addr  = gnt_id ? m1_addr  : m0_addr;
         mem_wdata = gnt_id ? m1_wdata : m0_wdata;
      end
   end

   // An owner grant is a grant that went to the master currently holding the
   // lock. The count includes the grant that set the lock, so the owner gets
   // MAX_LOCK grants in a row before it must give the port up for a cycle.
   assign owner_gnt = gnt_any & own_q & (gnt_id == own_id_q);
   assign cnt_inc   = lock_cnt_q + CNT_ONE;

   // State update. Reads are tracked per master for the one-cycle return. The
   // lock is set by a locking transfer from a non-owner. It ends when the
   // owner sends an unlocked transfer, when the owner stops requesting, or on
   // the MAX_LOCK-th grant. At a timeout, last_q already points at the owner,
   // so the round-robin tie-break hands the next cycle to the other master
   // with no extra logic.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q     <= 1'b1;
         own_q      <= 1'b0;
         own_id_q   <= 1'b0;
         lock_cnt_q <= '0;
         rpend_q    <= 2'b00;
      end else begin
         rpend_q <= {m1_gnt & ~m1_we, m0_gnt & ~m0_we};

         if (gnt_any) begin
            last_q <= gnt_id;
         end

         if (owner_gnt) begin
            if ((cnt_inc == CNT_MAX) || !sel_lock) begin
               own_q      <= 1'b0;
               lock_cnt_q <= '0;
            end else begin
               lock_cnt_q <= cnt_inc;
            end
         end else if (gnt_any && sel_lock) begin
            own_q      <= 1'b1;
            own_id_q   <= gnt_id;
            lock_cnt_q <= CNT_ONE;
         end else if (own_q) begin
            own_q      <= 1'b0;
            lock_cnt_q <= '0;
         end
      end
   end

   // Read return. The valid flags are the registered read-pending bits, and
   // the data is gated so that an idle master always sees zero.
   always_comb begin
      m0_rvalid = rpend_q[0];
      m1_rvalid = rpend_q[1];
      m0_rdata  = rpend_q[0] ? mem_rdata : '0;
      m1_rdata  = rpend_q[1] ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. A small memory model returns a
// recognisable word for every read: 0x1234 at address 0x010, otherwise
// 0xCAFE0000 | addr. Each expected value below is written out by hand.
// Inputs change 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        m0_req, m0_we, m0_lock;
   logic [11:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_gnt, m0_rvalid;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_we, m1_lock;
   logic [11:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt, m1_rvalid;
   logic [31:0] m1_rdata;
   logic        mem_en, mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int num_asserts = 0;
   int num_failures = 0;

   dmem_arbiter #(.DM_ADDRESS(12), .DATA_WIDTH(32), .MAX_LOCK(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Free-running 10 ns clock
   always #5 clk_i = ~clk_i;

   // Memory model: read data appears the cycle after a read access
   always @(posedge clk_i) begin
      if (mem_en && !mem_we) begin
         if (mem_addr == 12'h010) mem_rdata <= 32'h0000_1234;
         else                     mem_rdata <= 32'hCAFE_0000 | {20'h0, mem_addr};
      end
   end

   // Watchdog so the run always ends on its own
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input bit id, input logic req, input logic we,
                                input logic lock, input logic [11:0] addr,
                                input logic [31:0] wdata);
      if (id == 1'b0) begin
         m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      num_asserts++;
      assert (observed === expected) else begin
         num_failures++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   initial begin
      rst_ni = 1'b0;
      applyStimulus(0, 1, 0, 0, 12'h010, 32'h0);
      applyStimulus(1, 0, 0, 0, 12'h000, 32'h0);

      // Reset: a pending request must not be granted
      sample();
      checkOutput("rst_m0_gnt",    m0_gnt,    0);
      checkOutput("rst_mem_en",    mem_en,    0);
      checkOutput("rst_mem_addr",  mem_addr,  0);
      checkOutput("rst_m0_rvalid", m0_rvalid, 0);
      checkOutput("rst_m1_rdata",  m1_rdata,  0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Single m0 read of 0x010
      sample();
      checkOutput("t1_m0_gnt",    m0_gnt,   1);
      checkOutput("t1_m1_gnt",    m1_gnt,   0);
      checkOutput("t1_mem_en",    mem_en,   1);
      checkOutput("t1_mem_we",    mem_we,   0);
      checkOutput("t1_mem_addr",  mem_addr, 12'h010);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 12'h000, 32'h0);
      applyStimulus(1, 1, 1, 0, 12'h020, 32'hDEAD_BEEF);
      sample();
      checkOutput("t1_m0_rvalid", m0_rvalid, 1);
      checkOutput("t1_m0_rdata",  m0_rdata,  32'h0000_1234);
      checkOutput("t1_m1_rvalid", m1_rvalid, 0);
      checkOutput("t1_m1_rdata",  m1_rdata,  0);
      checkOutput("w_m1_gnt",     m1_gnt,    1);
      checkOutput("w_mem_we",     mem_we,    1);
      checkOutput("w_mem_wdata",  mem_wdata, 32'hDEAD_BEEF);

      // Both masters reading: alternate m0, m1, m0, m1
      nextCycle();
      applyStimulus(0, 1, 0, 0, 12'h100, 32'h0);
      applyStimulus(1, 1, 0, 0, 12'h200, 32'h0);
      sample();
      checkOutput("rr0_m0_gnt",    m0_gnt,    1);
      checkOutput("rr0_m1_gnt",    m1_gnt,    0);
      checkOutput("rr0_m1_rvalid", m1_rvalid, 0);
      checkOutput("rr0_mem_addr",  mem_addr,  12'h100);
      nextCycle();
      applyStimulus(0, 1, 0, 0, 12'h101, 32'h0);
      sample();
      checkOutput("rr1_m1_gnt",    m1_gnt,    1);
      checkOutput("rr1_m0_gnt",    m0_gnt,    0);
      checkOutput("rr1_m0_rvalid", m0_rvalid, 1);
      checkOutput("rr1_m0_rdata",  m0_rdata,  32'hCAFE_0100);
      checkOutput("rr1_mem_addr",  mem_addr,  12'h200);
      nextCycle();
      applyStimulus(1, 1, 0, 0, 12'h201, 32'h0);
      sample();
      checkOutput("rr2_m0_gnt",    m0_gnt,    1);
      checkOutput("rr2_m1_rvalid", m1_rvalid, 1);
      checkOutput("rr2_m1_rdata",  m1_rdata,  32'hCAFE_0200);
      checkOutput("rr2_m0_rvalid", m0_rvalid, 0);
      nextCycle();
      applyStimulus(0, 1, 1, 0, 12'h030, 32'h0000_0055);
      sample();
      checkOutput("rr3_m1_gnt",    m1_gnt,    1);
      checkOutput("rr3_m0_gnt",    m0_gnt,    0);
      checkOutput("rr3_m0_rvalid", m0_rvalid, 1);
      checkOutput("rr3_m0_rdata",  m0_rdata,  32'hCAFE_0101);

      // m0 write wins the tie; m1 starts a locked write burst
      nextCycle();
      applyStimulus(1, 1, 1, 1, 12'h300, 32'h0);
      sample();
      checkOutput("rr4_m0_gnt",    m0_gnt,    1);
      checkOutput("rr4_m1_gnt",    m1_gnt,    0);
      checkOutput("rr4_mem_we",    mem_we,    1);
      checkOutput("rr4_mem_addr",  mem_addr,  12'h030);
      checkOutput("rr4_m1_rvalid", m1_rvalid, 1);
      checkOutput("rr4_m1_rdata",  m1_rdata,  32'hCAFE_0201);

      // Lock burst: m1 owns cycles 0-7 while m0 waits with a read of 0x040
      for (int k = 0; k < 8; k++) begin
         nextCycle();
         applyStimulus(0, 1, 0, 0, 12'h040, 32'h0);
         applyStimulus(1, 1, 1, 1, 12'h300 + 12'(k), 32'(k));
         sample();
         checkOutput($sformatf("lk%0d_m1_gnt", k),   m1_gnt,   1);
         checkOutput($sformatf("lk%0d_m0_gnt", k),   m0_gnt,   0);
         checkOutput($sformatf("lk%0d_mem_we", k),   mem_we,   1);
         checkOutput($sformatf("lk%0d_mem_addr", k), mem_addr, 12'h300 + 12'(k));
      end
      if (1) begin
         // Timeout: m0 gets cycle 8, m1 holds its next transfer
         nextCycle();
         applyStimulus(1, 1, 1, 1, 12'h308, 32'h8);
         sample();
         checkOutput("lk8_m0_gnt",   m0_gnt,   1);
         checkOutput("lk8_m1_gnt",   m1_gnt,   0);
         checkOutput("lk8_mem_we",   mem_we,   0);
         checkOutput("lk8_mem_addr", mem_addr, 12'h040);
         checkOutput("lk8_cnt",      dut.lock_cnt_q, 0);
      end
      nextCycle();
      applyStimulus(0, 1, 0, 0, 12'h041, 32'h0);
      sample();
      checkOutput("lk9_m1_gnt",    m1_gnt,    1);
      checkOutput("lk9_m0_gnt",    m0_gnt,    0);
      checkOutput("lk9_mem_we",    mem_we,    1);
      checkOutput("lk9_mem_addr",  mem_addr,  12'h308);
      checkOutput("lk9_m0_rvalid", m0_rvalid, 1);
      checkOutput("lk9_m0_rdata",  m0_rdata,  32'hCAFE_0040);

      // Owner m1 (re-locked) drops its request: m0 granted in the same cycle
      nextCycle();
      applyStimulus(1, 0, 0, 0, 12'h000, 32'h0);
      sample();
      checkOutput("drop_own_before", dut.own_q, 1);
      checkOutput("drop_m0_gnt",     m0_gnt,    1);
      checkOutput("drop_m1_gnt",     m1_gnt,    0);
      checkOutput("drop_mem_addr",   mem_addr,  12'h041);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 12'h000, 32'h0);
      applyStimulus(1, 1, 0, 0, 12'h050, 32'h0);
      sample();
      checkOutput("drop_own_after",  dut.own_q, 0);
      checkOutput("drop_m0_rvalid",  m0_rvalid, 1);
      checkOutput("drop_m0_rdata",   m0_rdata,  32'hCAFE_0041);
      checkOutput("solo_m1_gnt",     m1_gnt,    1);

      // m0 locked burst of three writes with m1 waiting on a read of 0x051
      nextCycle();
      applyStimulus(0, 1, 1, 1, 12'h060, 32'h0000_0060);
      applyStimulus(1, 1, 0, 0, 12'h051, 32'h0);
      sample();
      checkOutput("b0_m0_gnt",    m0_gnt,    1);
      checkOutput("b0_m1_gnt",    m1_gnt,    0);
      checkOutput("b0_m1_rvalid", m1_rvalid, 1);
      checkOutput("b0_m1_rdata",  m1_rdata,  32'hCAFE_0050);
      nextCycle();
      applyStimulus(0, 1, 1, 1, 12'h061, 32'h0000_0061);
      sample();
      checkOutput("b1_m0_gnt",    m0_gnt,    1);
      checkOutput("b1_m1_gnt",    m1_gnt,    0);
      checkOutput("b1_cnt",       dut.lock_cnt_q, 1);
      nextCycle();
      applyStimulus(0, 1, 1, 0, 12'h062, 32'h0000_0062);
      sample();
      checkOutput("b2_m0_gnt",    m0_gnt,    1);
      checkOutput("b2_m1_gnt",    m1_gnt,    0);
      checkOutput("b2_mem_wdata", mem_wdata, 32'h0000_0062);
      checkOutput("b2_cnt",       dut.lock_cnt_q, 2);
      nextCycle();
      applyStimulus(0, 1, 1, 0, 12'h063, 32'h0000_0063);
      sample();
      checkOutput("b3_m1_gnt",    m1_gnt,    1);
      checkOutput("b3_m0_gnt",    m0_gnt,    0);
      checkOutput("b3_mem_addr",  mem_addr,  12'h051);
      checkOutput("b3_cnt",       dut.lock_cnt_q, 0);
      checkOutput("b3_own",       dut.own_q, 0);
      nextCycle();
      applyStimulus(1, 0, 0, 0, 12'h000, 32'h0);
      sample();
      checkOutput("b4_m0_gnt",    m0_gnt,    1);
      checkOutput("b4_m1_rvalid", m1_rvalid, 1);
      checkOutput("b4_m1_rdata",  m1_rdata,  32'hCAFE_0051);

      // m0 read granted, then reset asserted before the capturing edge
      nextCycle();
      applyStimulus(0, 1, 0, 0, 12'h011, 32'h0);
      sample();
      checkOutput("r_m0_gnt_pre", m0_gnt, 1);
      #2 rst_ni = 1'b0;
      #1;
      checkOutput("r_m0_gnt_rst", m0_gnt,    0);
      checkOutput("r_mem_en_rst", mem_en,    0);
      checkOutput("r_m0_rdata",   m0_rdata,  0);
      nextCycle();
      rst_ni = 1'b1;
      applyStimulus(0, 1, 0, 0, 12'h012, 32'h0);
      applyStimulus(1, 1, 0, 0, 12'h210, 32'h0);
      sample();
      checkOutput("r_m0_rvalid",  m0_rvalid, 0);
      checkOutput("r_tie_m0_gnt", m0_gnt,    1);
      checkOutput("r_tie_m1_gnt", m1_gnt,    0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 12'h000, 32'h0);
      applyStimulus(1, 0, 0, 0, 12'h000, 32'h0);
      sample();
      checkOutput("r_post_rvalid", m0_rvalid, 1);
      checkOutput("r_post_rdata",  m0_rdata,  32'hCAFE_0012);
      checkOutput("r_post_m1",     m1_rvalid, 0);
      checkOutput("idle_mem_en",   mem_en,    0);

      $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single data-memory/IO port (word array plus memory-mapped HEX/LED/LCD/switch region) between the CPU load/store path (m0) and a loader/DMA master (m1).
- Per-cycle round-robin with an optional bounded lock for back-to-back bursts.
- Drives one memory request per cycle and returns read data one cycle later to the granted master.

Parameters:
- DM_ADDRESS, 12, word-address width of the memory port
- DATA_WIDTH, 32, data width
- MAX_LOCK, 8, maximum consecutive granted cycles a locked owner may hold the port (must be ≥2)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- m0_req / m1_req  input  1  request valid
- m0_we / m1_we  input  1  1 = write, 0 = read
- m0_lock / m1_lock  input  1  request to keep ownership after this transfer
- m0_addr / m1_addr  input  DM_ADDRESS  word address
- m0_wdata / m1_wdata  input  DATA_WIDTH  write data
- m0_gnt / m1_gnt  output  1  request accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  output  1  read data valid (registered)
- m0_rdata / m1_rdata  output  DATA_WIDTH  read data
- mem_en  output  1  memory access this cycle
- mem_we  output  1  memory write strobe
- mem_addr  output  DM_ADDRESS  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- State: last_q (last granted master, reset 1 so m0 wins first tie), own_q (locked owner valid, reset 0), own_id_q, lock_cnt_q (reset 0), rpend_q[1:0] (reset 0).
- Reset: while rst_ni=0, gnt, mem_en, mem_we, and rvalid are all forced to 0. Address, data, and rdata outputs are 0. In-flight reads are discarded and are not replayed after reset.
- Grant selection, evaluated each cycle:
  1. If own_q=1 and owner req=1, grant the owner.
  2. Else if only one req, grant it.
  3. Else if both req, grant !last_q.
  4. Else no grant.
- At most one gnt per cycle.
- Memory mux: mem_en = any gnt. mem_we/mem_addr/mem_wdata come from the granted master. With no grant, mem_en=0, mem_we=0, and addr/wdata=0.
- Read latency: a granted read sets rpend_q[id] at the clock edge. Next cycle, mN_rvalid=1 and mN_rdata=mem_rdata, for exactly one cycle per read. Writes produce no rvalid.
- Pipelining: back-to-back reads are allowed; one read may complete every cycle. rdata=0 whenever rvalid=0.
- last_q updates to the granted id on every grant.
- Lock:
  - A granted transfer with lock=1 sets own_q=1 and own_id_q=id.
  - lock_cnt_q increments on each owner grant.
  - A granted owner transfer with lock=0 clears own_q at that edge.
  - If the owner drops req, own_q clears at that edge and the cycle is arbitrated normally.
- Lock timeout: when the owner receives its MAX_LOCK-th consecutive grant, own_q clears regardless of lock, and lock_cnt_q resets to 0.
  - On the following cycle, if the other master is requesting, it wins, since last_q = owner.
  - The owner may re-lock only on its next grant.
- lock_cnt_q resets to 0 whenever own_q clears.
- A non-owner requesting while the owner holds the lock waits with gnt=0. Its signals must stay stable until granted.
- Simultaneous events: a lock release and a new request by the other master in the same cycle are resolved by the next-cycle arbitration, with no bubble.

Test Plan:
- Reset, then m0_req=1 read addr 0x010 while m1 idle, mem_rdata=0x1234 next cycle → m0_gnt=1 in cycle 0; m0_rvalid=1 and m0_rdata=0x1234 in cycle 1; m1 outputs 0.
- Both request reads every cycle for 4 cycles → grants m0, m1, m0, m1; rvalid pulses follow one cycle behind each grant on the matching master.
- m1 write with m1_lock=1 for 10 cycles while m0_req held, MAX_LOCK=8 → m1 granted cycles 0–7; m0 granted cycle 8; m1 granted cycle 9; mem_we=1 only on m1 grants.
- m0 locked burst of 3 writes (lock=1,1,0) with m1 requesting → m0 gets 3 grants; m1 granted on the 4th cycle; lock_cnt_q=0 afterwards.
- m0 read granted, rst_ni asserted low mid-cycle before the next edge → m0_rvalid stays 0; after release, the first tie goes to m0.
- Owner m1 drops req while locked with m0 requesting → m0 granted in that same cycle; own_q=0.
